// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage (master) and memory (slave).
// Only one request is outstanding at a time. The master holds its request
// fields stable until the slave acknowledges the transfer.
interface mem_access_if #(
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [DATA_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access.sv
// MIPS memory-access stage. Handles byte, halfword and word loads and stores
// over a single-outstanding request/ack bus. Load data is sign- or
// zero-extended. Each retired instruction produces one registered write-back,
// and the upstream pipeline is stalled while a bus transfer is pending.
module mem_access #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [3:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              ex_wreg,
    input  logic [4:0]        ex_waddr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              stall_req,
    mem_access_if.master      bus,
    output logic              write_enable,
    output logic [4:0]        write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              addr_error,
    output logic [DATA_W-1:0] bad_addr
);

    typedef enum logic {
        IDLE,
        BUS
    } state_t;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LBU  = 4'd2,
        OP_LH   = 4'd3,
        OP_LHU  = 4'd4,
        OP_LW   = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_t;

    state_t            state_q;
    logic              bus_req_q;
    logic              bus_we_q;
    logic [DATA_W-1:0] bus_addr_q;
    logic [3:0]        bus_be_q;
    logic [DATA_W-1:0] bus_wdata_q;
    logic [3:0]        op_q;
    logic [1:0]        lane_q;
    logic              wreg_q;
    logic [4:0]        waddr_q;
    logic              write_enable_q;
    logic [4:0]        write_addr_q;
    logic [DATA_W-1:0] write_data_q;
    logic              addr_error_q;
    logic [DATA_W-1:0] bad_addr_q;

    logic              is_load;
    logic              is_store;
    logic              is_mem;
    logic              size_half;
    logic              size_word;
    logic              misaligned;
    logic [3:0]        be_d;
    logic [DATA_W-1:0] wdata_d;
    logic [7:0]        rbyte;
    logic [15:0]       rhalf;
    logic [DATA_W-1:0] load_data;

    // Decode the execute-stage op: direction, access size, alignment and lane steering
    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        size_half = 1'b0;
        size_word = 1'b0;
        case (ex_mem_op)
            OP_LB, OP_LBU:  is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load   = 1'b1;
                size_half = 1'b1;
            end
            OP_LW: begin
                is_load   = 1'b1;
                size_word = 1'b1;
            end
            OP_SB:          is_store = 1'b1;
            OP_SH: begin
                is_store  = 1'b1;
                size_half = 1'b1;
            end
            OP_SW: begin
                is_store  = 1'b1;
                size_word = 1'b1;
            end
            default: ;
        endcase
        is_mem     = is_load | is_store;
        misaligned = (size_half && ex_addr[0]) || (size_word && (ex_addr[1:0] != 2'b00));
        if (size_word) begin
            be_d    = 4'b1111;
            wdata_d = ex_store_data;
        end else if (size_half) begin
            be_d    = ex_addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{ex_store_data[15:0]}};
        end else begin
            be_d    = 4'b0001 << ex_addr[1:0];
            wdata_d = {4{ex_store_data[7:0]}};
        end
    end

    // Select the addressed lane of the returned word and extend it to register width
    always_comb begin
        case (lane_q)
            2'd0:    rbyte = bus.bus_rdata[7:0];
            2'd1:    rbyte = bus.bus_rdata[15:8];
            2'd2:    rbyte = bus.bus_rdata[23:16];
            default: rbyte = bus.bus_rdata[31:24];
        endcase
        rhalf = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (op_q)
            OP_LB:   load_data = {{(DATA_W-8){rbyte[7]}}, rbyte};
            OP_LBU:  load_data = {{(DATA_W-8){1'b0}}, rbyte};
            OP_LH:   load_data = {{(DATA_W-16){rhalf[15]}}, rhalf};
            OP_LHU:  load_data = {{(DATA_W-16){1'b0}}, rhalf};
            default: load_data = bus.bus_rdata;
        endcase
    end

    // Stall upstream while an aligned memory op is being launched or waiting for its ack
    always_comb begin
        if (rst) begin
            stall_req = 1'b0;
        end else if (state_q == IDLE) begin
            stall_req = ex_valid && is_mem && !misaligned;
        end else begin
            stall_req = !bus.bus_ack;
        end
    end

    // Stage FSM with registered bus, write-back and error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_be_q       <= '0;
            bus_wdata_q    <= '0;
            op_q           <= '0;
            lane_q         <= '0;
            wreg_q         <= 1'b0;
            waddr_q        <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            addr_error_q   <= 1'b0;
            bad_addr_q     <= '0;
        end else begin
            write_enable_q <= 1'b0;
            addr_error_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        if (!is_mem) begin
                            write_enable_q <= ex_wreg;
                            write_addr_q   <= ex_waddr;
                            write_data_q   <= ex_wdata;
                        end else if (misaligned) begin
                            addr_error_q <= 1'b1;
                            bad_addr_q   <= ex_addr;
                        end else begin
                            state_q     <= BUS;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= is_store;
                            bus_addr_q  <= {ex_addr[DATA_W-1:2], 2'b00};
                            bus_be_q    <= be_d;
                            bus_wdata_q <= wdata_d;
                            op_q        <= ex_mem_op;
                            lane_q      <= ex_addr[1:0];
                            wreg_q      <= ex_wreg & is_load;
                            waddr_q     <= ex_waddr;
                        end
                    end
                end
                BUS: begin
                    if (bus.bus_ack) begin
                        state_q        <= IDLE;
                        bus_req_q      <= 1'b0;
                        write_enable_q <= wreg_q;
                        write_addr_q   <= waddr_q;
                        write_data_q   <= load_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign write_enable  = write_enable_q;
    assign write_addr    = write_addr_q;
    assign write_data    = write_data_q;
    assign addr_error    = addr_error_q;
    assign bad_addr      = bad_addr_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access. Expected write-backs are queued when an
// instruction is driven and checked when write_enable fires. Bus, stall and
// error behaviour is checked inline by each scenario task.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_addr;
    logic [31:0] ex_store_data;
    logic        ex_wreg;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        stall_req;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        addr_error;
    logic [31:0] bad_addr;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wb_t;
    wb_t exp_q[$];

    mem_access_if #(.DATA_W(32)) bus ();
    assign bus.bus_ack   = bus_ack;
    assign bus.bus_rdata = bus_rdata;

    mem_access #(.DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .ex_mem_op     (ex_mem_op),
        .ex_addr       (ex_addr),
        .ex_store_data (ex_store_data),
        .ex_wreg       (ex_wreg),
        .ex_waddr      (ex_waddr),
        .ex_wdata      (ex_wdata),
        .stall_req     (stall_req),
        .bus           (bus.master),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .addr_error    (addr_error),
        .bad_addr      (bad_addr)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write-back must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && write_enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got addr=%0d data=%h, required no write-back", write_addr, write_data);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                if (write_addr !== e.a || write_data !== e.d) begin
                    errors++;
                    $display("FAIL wb_value: got addr=%0d data=%h, required addr=%0d data=%h",
                             write_addr, write_data, e.a, e.d);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
        ex_valid = 1'b1; ex_mem_op = 4'd5; ex_addr = 32'h10; ex_store_data = '0;
        ex_wreg = 1'b1; ex_waddr = 5'd1; ex_wdata = '0;
        step(); step();
        checks++;
        if (stall_req !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b, required 0", stall_req);
        end
        checks++;
        if (bus.bus_req !== 1'b0 || bus.bus_we !== 1'b0 || bus.bus_addr !== 32'h0 ||
            bus.bus_be !== 4'h0 || bus.bus_wdata !== 32'h0 || write_enable !== 1'b0 ||
            write_addr !== 5'd0 || write_data !== 32'h0 || addr_error !== 1'b0 || bad_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wd=%h wen=%b wa=%0d wdat=%h err=%b bad=%h, required all 0",
                     bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata,
                     write_enable, write_addr, write_data, addr_error, bad_addr);
        end
        ex_valid = 1'b0;
        rst = 1'b0;
        step();
    endtask

    task automatic alu_op(input logic [3:0] op, input logic wreg, input logic [4:0] waddr, input logic [31:0] wdata);
        ex_valid = 1'b1; ex_mem_op = op; ex_addr = 32'h0000_0103; ex_wreg = wreg;
        ex_waddr = waddr; ex_wdata = wdata;
        if (wreg) exp_q.push_back('{waddr, wdata});
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++; $display("FAIL alu_stall: got %b, required 0", stall_req);
        end
        step();
        checks++;
        if (write_enable !== wreg || bus.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL alu_wen: got wen=%b req=%b, required wen=%b req=0", write_enable, bus.bus_req, wreg);
        end
    endtask

    task automatic test_alu_passthrough();
        alu_op(4'd0,  1'b1, 5'd3,  32'h1234_5678);
        alu_op(4'd12, 1'b1, 5'd9,  32'hCAFE_0001);
        alu_op(4'd0,  1'b1, 5'd0,  32'h0000_0001);
        alu_op(4'd0,  1'b0, 5'd4,  32'hFFFF_FFFF);
        ex_valid = 1'b0;
        step();
        checks++;
        if (write_enable !== 1'b0) begin
            errors++; $display("FAIL alu_idle_wen: got %b, required 0", write_enable);
        end
    endtask

    // Memory op acked in cycle k (k >= 1); leaves the bench in cycle k+1 with ex_valid low
    task automatic mem_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic wreg, input logic [4:0] waddr, input logic [31:0] rdata,
                          input int unsigned k, input logic [3:0] exp_be, input logic [31:0] exp_bwdata,
                          input logic st, input logic [31:0] exp_wb);
        logic [31:0] exp_baddr;
        exp_baddr = {addr[31:2], 2'b00};
        ex_valid = 1'b1; ex_mem_op = op; ex_addr = addr; ex_store_data = sdata;
        ex_wreg = wreg; ex_waddr = waddr; ex_wdata = 32'h5555_AAAA;
        if (!st && wreg) exp_q.push_back('{waddr, exp_wb});
        for (int unsigned c = 0; c <= k; c++) begin
            if (c > 0) begin
                step();
                checks++;
                if (bus.bus_req !== 1'b1 || bus.bus_we !== st || bus.bus_addr !== exp_baddr ||
                    bus.bus_be !== exp_be || (st && bus.bus_wdata !== exp_bwdata)) begin
                    errors++;
                    $display("FAIL bus_fields c=%0d: got req=%b we=%b addr=%h be=%b wd=%h, required req=1 we=%b addr=%h be=%b wd=%h",
                             c, bus.bus_req, bus.bus_we, bus.bus_addr, bus.bus_be, bus.bus_wdata,
                             st, exp_baddr, exp_be, exp_bwdata);
                end
            end
            if (c == k) begin
                bus_ack = 1'b1;
                bus_rdata = rdata;
            end
            #1;
            checks++;
            if (stall_req !== (c != k)) begin
                errors++; $display("FAIL mem_stall c=%0d: got %b, required %b", c, stall_req, (c != k));
            end
        end
        step();
        bus_ack = 1'b0; ex_valid = 1'b0; bus_rdata = $urandom;
        checks++;
        if (bus.bus_req !== 1'b0 || write_enable !== (!st && wreg)) begin
            errors++;
            $display("FAIL mem_done: got req=%b wen=%b, required req=0 wen=%b", bus.bus_req, write_enable, (!st && wreg));
        end
    endtask

    task automatic test_loads();
        mem_op(4'd1, 32'h103, 32'h0, 1'b1, 5'd5, 32'h80FF_0000, 3, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80);
        step();
        mem_op(4'd2, 32'h103, 32'h0, 1'b1, 5'd6, 32'h80FF_0000, 3, 4'b1000, 32'h0, 1'b0, 32'h0000_0080);
        step();
        mem_op(4'd3, 32'h102, 32'h0, 1'b1, 5'd7, 32'h8001_7FFF, 2, 4'b1100, 32'h0, 1'b0, 32'hFFFF_8001);
        mem_op(4'd4, 32'h100, 32'h0, 1'b1, 5'd8, 32'h1234_F00D, 1, 4'b0011, 32'h0, 1'b0, 32'h0000_F00D);
        mem_op(4'd1, 32'h101, 32'h0, 1'b1, 5'd10, 32'h0000_7F00, 1, 4'b0010, 32'h0, 1'b0, 32'h0000_007F);
        mem_op(4'd5, 32'h108, 32'h0, 1'b0, 5'd11, 32'h1111_2222, 1, 4'b1111, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_stores();
        mem_op(4'd7, 32'h202, 32'hAAAA_1234, 1'b1, 5'd12, 32'h0, 2, 4'b1100, 32'h1234_1234, 1'b1, 32'h0);
        mem_op(4'd6, 32'h201, 32'h0000_005A, 1'b1, 5'd13, 32'h0, 1, 4'b0010, 32'h5A5A_5A5A, 1'b1, 32'h0);
        step();
    endtask

    task automatic misaligned_op(input logic [3:0] op, input logic [31:0] addr);
        ex_valid = 1'b1; ex_mem_op = op; ex_addr = addr; ex_wreg = 1'b1; ex_waddr = 5'd14;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin
            errors++; $display("FAIL misalign_stall: got %b, required 0", stall_req);
        end
        step();
        ex_valid = 1'b0;
        checks++;
        if (addr_error !== 1'b1 || bad_addr !== addr || write_enable !== 1'b0 || bus.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: got err=%b bad=%h wen=%b req=%b, required err=1 bad=%h wen=0 req=0",
                     addr_error, bad_addr, write_enable, bus.bus_req, addr);
        end
        step();
        checks++;
        if (addr_error !== 1'b0 || bad_addr !== addr || bus.bus_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_after: got err=%b bad=%h req=%b, required err=0 bad=%h req=0",
                     addr_error, bad_addr, bus.bus_req, addr);
        end
    endtask

    task automatic test_misaligned();
        misaligned_op(4'd5, 32'h301);
        misaligned_op(4'd7, 32'h203);
    endtask

    task automatic test_reset_mid_transfer();
        ex_valid = 1'b1; ex_mem_op = 4'd5; ex_addr = 32'h400; ex_wreg = 1'b1; ex_waddr = 5'd15;
        step();
        step();
        checks++;
        if (bus.bus_req !== 1'b1) begin
            errors++; $display("FAIL rmid_req_before: got %b, required 1", bus.bus_req);
        end
        rst = 1'b1; ex_valid = 1'b0;
        step();
        checks++;
        if (bus.bus_req !== 1'b0 || stall_req !== 1'b0) begin
            errors++; $display("FAIL rmid_req_after: got req=%b stall=%b, required 0 0", bus.bus_req, stall_req);
        end
        rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        step();
        bus_ack = 1'b0;
        step();
        checks++;
        if (write_enable !== 1'b0 || bus.bus_req !== 1'b0) begin
            errors++; $display("FAIL rmid_late_ack: got wen=%b req=%b, required 0 0", write_enable, bus.bus_req);
        end
    endtask

    task automatic test_back_to_back();
        mem_op(4'd8, 32'h500, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0, 1, 4'b1111, 32'hDEAD_BEEF, 1'b1, 32'h0);
        mem_op(4'd5, 32'h504, 32'h0, 1'b1, 5'd7, 32'hCAFE_F00D, 1, 4'b1111, 32'h0, 1'b0, 32'hCAFE_F00D);
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_loads();
        test_stores();
        test_misaligned();
        test_reset_mid_transfer();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL wb_missing: got %0d pending write-backs, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
